alu_op_sequencer: RTL and testbench

Front-end that drives the datapath ALU on behalf of the control unit. It accepts one operation request over a valid/ready handshake and drives the operands, then the select code, onto the ALU inputs. It waits a per-op settle time, then captures the ALU low/high/carry outputs into registered Z results with status flags. The result is returned over a second valid/ready handshake. The ALU evaluates only on a select-code change, so this block guarantees a select transition for every operation.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_settle_counter.sv | 34 +++
 rtl/alu_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU operation sequencer: default widths,
// ALU op codes, sequencer state encoding and the settle counter width.
package alu_pkg;

    localparam int WORD_DEF  = 32;
    localparam int SEL_W_DEF = 6;
    localparam int CNT_W     = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_DIV  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_IDLE = 63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter
// Loadable down-counter that times the ALU settle window.
// Ports:
//   clk, clr   : clock, async active-high reset
//   load       : load load_val this cycle (has priority over dec)
//   load_val   : value to load (settle cycles minus one)
//   dec        : decrement while non-zero
//   zero       : count == 0
module alu_settle_counter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Drives the datapath ALU for one request at a time: presents operands,
// then the select code, waits the per-op settle time, captures the ALU
// results plus status flags and hands them back over a valid/ready pair.
// Ports:
//   clk, clr                       : clock, async active-high reset
//   req_valid/req_ready, req_a/b/op: request handshake and payload
//   alu_a/alu_b/alu_sel            : registered drive to the ALU
//   alu_low/alu_high/alu_carry     : ALU results
//   rsp_valid/rsp_ready            : response handshake
//   z_low/z_high/z_carry           : captured results
//   z_zero/z_neg/bad_op/div_zero   : status flags
//   busy                           : not in IDLE
//
// state | meaning
// IDLE  | ready for a request, select parked on the idle code
// LOAD  | operands on the ALU, select still idle (bad op: build response)
// EXEC  | select driven, settle counter running
// RESP  | result held until the consumer takes it
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WORD         = WORD_DEF,
    parameter int SEL_W        = SEL_W_DEF,
    parameter int SETTLE_BASIC = 1,
    parameter int SETTLE_DIV   = 4,
    parameter int IDLE_SEL     = OP_IDLE
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WORD-1:0]  req_a,
    input  logic [WORD-1:0]  req_b,
    input  logic [SEL_W-1:0] req_op,
    output logic [WORD-1:0]  alu_a,
    output logic [WORD-1:0]  alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WORD-1:0]  alu_low,
    input  logic [WORD-1:0]  alu_high,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WORD-1:0]  z_low,
    output logic [WORD-1:0]  z_high,
    output logic             z_carry,
    output logic             z_zero,
    output logic             z_neg,
    output logic             bad_op,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [SEL_W-1:0] SEL_IDLE  = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W-1:0] SEL_DIV   = SEL_W'(OP_DIV);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(OP_XOR);
    localparam logic [CNT_W-1:0] CNT_BASIC = CNT_W'(SETTLE_BASIC - 1);
    localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(SETTLE_DIV - 1);

    state_t           state;
    logic [SEL_W-1:0] lat_op;
    logic             lat_bad;
    logic             cnt_zero;

    assign req_ready = (state == IDLE) && !clr;
    assign busy      = (state != IDLE);

    alu_settle_counter u_settle (
        .clk      (clk),
        .clr      (clr),
        .load     (state == LOAD),
        .load_val ((lat_op == SEL_DIV) ? CNT_DIV : CNT_BASIC),
        .dec      (state == EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            lat_op    <= '0;
            lat_bad   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= SEL_IDLE;
            rsp_valid <= 1'b0;
            z_low     <= '0;
            z_high    <= '0;
            z_carry   <= 1'b0;
            z_zero    <= 1'b0;
            z_neg     <= 1'b0;
            bad_op    <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_op  <= req_op;
                        lat_bad <= (req_op > SEL_MAX);
                        // An undefined op never reaches the ALU pins.
                        if (req_op <= SEL_MAX) begin
                            alu_a <= req_a;
                            alu_b <= req_b;
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (lat_bad) begin
                        z_low     <= '0;
                        z_high    <= '0;
                        z_carry   <= 1'b0;
                        z_zero    <= 1'b1;
                        z_neg     <= 1'b0;
                        bad_op    <= 1'b1;
                        div_zero  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        // Operands have been stable for a cycle; the select
                        // change now triggers the ALU evaluation.
                        alu_sel <= lat_op;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_zero) begin
                        z_low     <= alu_low;
                        z_high    <= alu_high;
                        z_carry   <= alu_carry;
                        z_zero    <= (alu_low == '0);
                        z_neg     <= alu_low[WORD-1];
                        bad_op    <= 1'b0;
                        div_zero  <= (lat_op == SEL_DIV) && (alu_b == '0);
                        alu_sel   <= SEL_IDLE;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with a behavioural ALU that only
// produces valid results once its select has been stable for the op's
// settle time (garbage otherwise).
module tb_alu_op_sequencer;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] low;
        logic [31:0] high;
        logic        carry;
        logic        zero;
        logic        neg;
        logic        bad;
        logic        divz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_sel;
    logic [31:0] alu_low;
    logic [31:0] alu_high;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] z_low;
    logic [31:0] z_high;
    logic        z_carry;
    logic        z_zero;
    logic        z_neg;
    logic        bad_op;
    logic        div_zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[11];
    vec_t bp1;
    vec_t bp2;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .WORD(32), .SEL_W(6), .SETTLE_BASIC(1), .SETTLE_DIV(4), .IDLE_SEL(63)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_low(alu_low), .alu_high(alu_high), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .z_low(z_low), .z_high(z_high), .z_carry(z_carry),
        .z_zero(z_zero), .z_neg(z_neg),
        .bad_op(bad_op), .div_zero(div_zero), .busy(busy)
    );

    // Behavioural ALU: result valid only after the select has been held
    // for the op's settle time (1 cycle basic, 4 cycles divide).
    logic [5:0]  sel_q = 6'd63;
    logic [7:0]  age_q = 8'd0;
    logic [7:0]  age_eff;
    logic [7:0]  need;
    logic [32:0] sum33;

    always_comb begin
        age_eff   = (alu_sel != sel_q) ? 8'd0 :
                    ((age_q == 8'd255) ? age_q : age_q + 8'd1);
        need      = (alu_sel == 6'd2) ? 8'd3 : 8'd0;
        sum33     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_low   = 32'hDEAD_BEEF;
        alu_high  = 32'hBAD0_BAD0;
        alu_carry = 1'b1;
        if ((alu_sel <= 6'd5) && (age_eff >= need)) begin
            alu_high  = 32'd0;
            alu_carry = 1'b0;
            case (alu_sel)
                6'd0: begin alu_low = sum33[31:0]; alu_carry = sum33[32]; end
                6'd1: begin alu_low = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
                6'd2: begin
                    if (alu_b == 32'd0) begin
                        alu_low  = 32'hFFFF_FFFF;
                        alu_high = alu_a;
                    end else begin
                        alu_low  = alu_a / alu_b;
                        alu_high = alu_a % alu_b;
                    end
                end
                6'd3: alu_low = alu_a & alu_b;
                6'd4: alu_low = alu_a | alu_b;
                default: alu_low = alu_a ^ alu_b;
            endcase
        end
    end

    always @(posedge clk) begin
        sel_q <= alu_sel;
        age_q <= age_eff;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; returns at the negedge where
    // rsp_valid is first seen high.
    task automatic track_to_rsp(input vec_t v);
        int   lat;
        logic sel_ok;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("load_rsp_valid", rsp_valid, 1'b0);
        chk("load_sel", 32'(alu_sel), 32'd63);
        if (!v.bad) begin
            chk("load_a", alu_a, v.a);
            chk("load_b", alu_b, v.b);
        end
        lat    = 0;
        sel_ok = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!rsp_valid) begin
                if (v.bad ? (alu_sel != 6'd63) : (alu_sel != v.op)) sel_ok = 1'b0;
            end
        end while (!rsp_valid && lat < 40);
        chk("latency", 32'(lat), 32'(v.lat));
        chk1("exec_sel", sel_ok, 1'b1);
        chk("z_low", z_low, v.low);
        chk("z_high", z_high, v.high);
        chk1("z_carry", z_carry, v.carry);
        chk1("z_zero", z_zero, v.zero);
        chk1("z_neg", z_neg, v.neg);
        chk1("bad_op", bad_op, v.bad);
        chk1("div_zero", div_zero, v.divz);
        chk("resp_sel", 32'(alu_sel), 32'd63);
        chk1("resp_req_ready", req_ready, 1'b0);
    endtask

    task automatic release_rsp(input logic [31:0] exp_low);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("post_rsp_valid", rsp_valid, 1'b0);
        chk1("post_req_ready", req_ready, 1'b1);
        chk("post_z_low_kept", z_low, exp_low);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int bad_cycles;
        req_valid = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_op    = 6'd0;
        rsp_ready = 1'b0;

        //           a             b             op     low            high          c     z     n     bad   dz    lat
        vecs[0]  = '{32'd5,        32'd7,        6'd0,  32'd12,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{32'd3,        32'd10,       6'd1,  32'hFFFF_FFF9, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[2]  = '{32'd9,        32'd9,        6'd1,  32'd0,         32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{32'd100,      32'd7,        6'd2,  32'd14,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vecs[4]  = '{32'd5,        32'd0,        6'd2,  32'hFFFF_FFFF, 32'd5,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5};
        vecs[5]  = '{32'd1,        32'd2,        6'd9,  32'd0,         32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{32'hF0F0_1234, 32'h0FF0_FFFF, 6'd3, 32'h00F0_1234, 32'd0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{32'h8000_0000, 32'd1,       6'd4,  32'h8000_0001, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 6'd5, 32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{32'hFFFF_FFFF, 32'd2,       6'd0,  32'd1,         32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{32'd4,        32'd4,        6'd63, 32'd0,         32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        bp1      = '{32'd20,       32'd22,       6'd0,  32'd42,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        bp2      = '{32'h1111,     32'h2222,     6'd0,  32'h3333,      32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        // Power-on reset
        #1 clr = 1'b1;
        #1;
        chk("rst_sel", 32'(alu_sel), 32'd63);
        chk("rst_z_low", z_low, 32'd0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_bad_op", bad_op, 1'b0);
        chk1("rst_z_zero", z_zero, 1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        #1;
        chk1("rst_release_ready", req_ready, 1'b1);

        // Table-driven ops
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            req_op    = vecs[i].op;
            chk1("accept_ready", req_ready, 1'b1);
            @(posedge clk);
            track_to_rsp(vecs[i]);
            release_rsp(vecs[i].low);
        end

        // Backpressure with a pending request
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = bp1.a;
        req_b     = bp1.b;
        req_op    = bp1.op;
        @(posedge clk);
        track_to_rsp(bp1);
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_a     = bp2.a;
            req_b     = bp2.b;
            req_op    = bp2.op;
            @(posedge clk);
            @(negedge clk);
            chk("bp_z_low", z_low, 32'd42);
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk1("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("bp_post_rsp_valid", rsp_valid, 1'b0);
        chk1("bp_post_ready", req_ready, 1'b1);
        chk1("bp_post_busy", busy, 1'b0);
        chk("bp_post_z_low", z_low, 32'd42);
        @(posedge clk);
        track_to_rsp(bp2);
        release_rsp(bp2.low);

        // Reset in the middle of a divide
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 32'd100;
        req_b     = 32'd7;
        req_op    = 6'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_exec_sel", 32'(alu_sel), 32'd2);
        clr = 1'b1;
        #1;
        chk("midrst_sel", 32'(alu_sel), 32'd63);
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk("midrst_z_low", z_low, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk1("midrst_z_zero", z_zero, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk1("midrst_release_ready", req_ready, 1'b1);
        bad_cycles = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || busy) bad_cycles++;
        end
        chk("midrst_no_rsp", 32'(bad_cycles), 32'd0);

        // Normal operation after the abort
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = vecs[3].a;
        req_b     = vecs[3].b;
        req_op    = vecs[3].op;
        @(posedge clk);
        track_to_rsp(vecs[3]);
        release_rsp(vecs[3].low);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
